// File: rtl/tcam_prio_enc_seg.sv
// tcam_prio_enc_seg: per-segment lowest-index encoder with hit and multi-hit flags
module tcam_prio_enc_seg #(
  parameter int SEG_WIDTH = 8
) (
  input  logic [SEG_WIDTH-1:0]         match,
  output logic [$clog2(SEG_WIDTH)-1:0] idx,
  output logic                         hit,
  output logic                         multi
);
  localparam int LW = $clog2(SEG_WIDTH);
  always_comb begin
    idx = '0;
    for (int j = SEG_WIDTH - 1; j >= 0; j--)
      if (match[j]) idx = LW'(j);
  end
  assign hit   = |match;
  assign multi = |(match & (match - SEG_WIDTH'(1)));
endmodule

// File: rtl/tcam_prio_enc.sv
// tcam_prio_enc: two-stage pipelined lowest-index priority encoder for a TCAM match vector
module tcam_prio_enc #(
  parameter int DEPTH      = 64,
  parameter int SEG_WIDTH  = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DEPTH-1:0]      s_match,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic                  m_hit,
  output logic                  m_multi,
  output logic                  m_valid,
  input  logic                  m_ready
);
  localparam int NSEG = DEPTH / SEG_WIDTH;
  localparam int LW   = $clog2(SEG_WIDTH);
  logic [NSEG-1:0][LW-1:0] seg_idx, st1_idx;
  logic [NSEG-1:0]         seg_hit, seg_multi, st1_hit, st1_multi;
  logic                    st1_valid, en1, en2, sel_multi;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    tcam_prio_enc_seg #(.SEG_WIDTH(SEG_WIDTH)) u_seg (
      .match(s_match[g*SEG_WIDTH +: SEG_WIDTH]),
      .idx  (seg_idx[g]),
      .hit  (seg_hit[g]),
      .multi(seg_multi[g])
    );
  end
  assign en2     = ~m_valid | m_ready;
  assign en1     = ~st1_valid | en2;
  assign s_ready = en1;
  always_ff @(posedge clk) begin
    if (rst) st1_valid <= 1'b0;
    else if (en1) st1_valid <= s_valid;
    if (en1 && s_valid) begin
      st1_idx   <= seg_idx;
      st1_hit   <= seg_hit;
      st1_multi <= seg_multi;
    end
  end
  // lowest hitting segment wins; its base offset plus the local index is the address
  always_comb begin
    sel_addr = '0;
    for (int j = NSEG - 1; j >= 0; j--)
      if (st1_hit[j]) sel_addr = ADDR_WIDTH'(j * SEG_WIDTH + int'(st1_idx[j]));
  end
  assign sel_multi = |st1_multi | |(st1_hit & (st1_hit - NSEG'(1)));
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_addr  <= '0;
      m_hit   <= 1'b0;
      m_multi <= 1'b0;
    end else if (en2) begin
      m_valid <= st1_valid;
      if (st1_valid) begin
        m_addr  <= sel_addr;
        m_hit   <= |st1_hit;
        m_multi <= sel_multi;
      end
    end
  end
endmodule

// File: tb/tb_tcam_prio_enc.sv
// tb_tcam_prio_enc: table-driven and randomized scoreboard checks for tcam_prio_enc
module tb_tcam_prio_enc;
  logic        clk = 0, rst = 1, s_valid = 0, m_ready = 1;
  logic [63:0] s_match = '0;
  logic        s_ready, m_hit, m_multi, m_valid;
  logic [5:0]  m_addr;
  int tests = 0, fails = 0;

  typedef struct { logic [5:0] a; logic h; logic mu; } res_t;
  typedef struct { logic [63:0] m; res_t r; } vec_t;
  res_t exp_q[$];
  logic prev_stall = 0;

  tcam_prio_enc #(.DEPTH(64), .SEG_WIDTH(8), .ADDR_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .s_match(s_match), .s_valid(s_valid), .s_ready(s_ready),
    .m_addr(m_addr), .m_hit(m_hit), .m_multi(m_multi), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  function automatic res_t model(logic [63:0] m);
    res_t r;
    int lo = 64;
    for (int i = 0; i < 64; i++) if (m[i] && lo == 64) lo = i;
    r.h  = (lo != 64);
    r.mu = ($countones(m) > 1);
    r.a  = r.h ? 6'(lo) : 6'd0;
    return r;
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, want);
    end
  endtask

  // drive one cycle's inputs at the falling edge, then score what the next rising edge will transfer
  task automatic step(input logic r, input logic v, input logic [63:0] mt, input logic mr, output logic acc);
    res_t e;
    @(negedge clk);
    rst = r; s_valid = v; s_match = mt; m_ready = mr;
    #1;
    acc = 0;
    if (r) begin
      exp_q.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall) chk("stall_valid", m_valid, 1);
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL extra_result: got addr %0d with no pending input", m_addr);
        end else begin
          e = exp_q[0];
          chk("addr", m_addr, e.a);
          chk("hit", m_hit, e.h);
          chk("multi", m_multi, e.mu);
          if (m_ready) void'(exp_q.pop_front());
        end
      end
      if (s_valid && s_ready) begin
        exp_q.push_back(model(mt));
        acc = 1;
      end
      prev_stall = m_valid && !m_ready;
    end
  endtask

  initial begin
    vec_t tbl[9];
    vec_t bp[4];
    logic acc;
    int k;
    tbl[0] = '{64'h0000_0020_0000_0000, '{6'd37, 1'b1, 1'b0}};
    tbl[1] = '{64'h8000_0000_0000_0220, '{6'd5,  1'b1, 1'b1}};
    tbl[2] = '{64'h0000_0000_0000_0018, '{6'd3,  1'b1, 1'b1}};
    tbl[3] = '{64'h0000_0000_0000_0000, '{6'd0,  1'b0, 1'b0}};
    tbl[4] = '{64'h0000_0000_0000_0001, '{6'd0,  1'b1, 1'b0}};
    tbl[5] = '{64'h8000_0000_0000_0000, '{6'd63, 1'b1, 1'b0}};
    tbl[6] = '{64'hFFFF_FFFF_FFFF_FFFF, '{6'd0,  1'b1, 1'b1}};
    tbl[7] = '{64'h0000_0000_0000_8100, '{6'd8,  1'b1, 1'b1}};
    tbl[8] = '{64'h0100_0000_0000_0000, '{6'd56, 1'b1, 1'b0}};
    step(1, 0, 0, 1, acc);
    step(1, 0, 0, 1, acc);
    step(0, 0, 0, 1, acc);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_hit", m_hit, 0);
    chk("rst_m_multi", m_multi, 0);
    chk("rst_s_ready", s_ready, 1);
    for (int t = 0; t < 9; t++) begin
      step(0, 1, tbl[t].m, 1, acc);
      chk("tbl_accept", acc, 1);
      chk("tbl_lat0", m_valid, 0);
      step(0, 0, 0, 1, acc);
      chk("tbl_lat1", m_valid, 0);
      step(0, 0, 0, 1, acc);
      chk("tbl_valid", m_valid, 1);
      chk("tbl_addr", m_addr, tbl[t].r.a);
      chk("tbl_hit", m_hit, tbl[t].r.h);
      chk("tbl_multi", m_multi, tbl[t].r.mu);
    end
    step(0, 0, 0, 1, acc);
    bp[0].m = 64'h0000_0000_0000_0100;
    bp[1].m = 64'h0000_0000_0000_0006;
    bp[2].m = 64'h0000_0000_0000_0000;
    bp[3].m = 64'h4000_0000_8000_0000;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      step(0, k < 4, k < 4 ? bp[k].m : 64'h0, !(c >= 2 && c <= 5), acc);
      if (c >= 2 && c <= 5) begin
        chk("bp_s_ready", s_ready, 0);
        chk("bp_held_addr", m_addr, 6'd8);
      end
      if (acc) k++;
    end
    chk("bp_all_accepted", k, 4);
    chk("bp_all_emerged", exp_q.size(), 0);
    step(0, 1, 64'h0000_0000_0010_0000, 0, acc);
    step(0, 1, 64'h0000_0000_0000_0400, 0, acc);
    step(1, 0, 0, 0, acc);
    chk("rst_full_m_valid", m_valid, 1);
    chk("rst_full_st1", s_ready, 0);
    step(0, 0, 0, 1, acc);
    chk("rst_mid_m_valid", m_valid, 0);
    chk("rst_mid_s_ready", s_ready, 1);
    for (int c = 0; c < 6; c++) begin
      step(0, 0, 0, 1, acc);
      chk("rst_no_stale", m_valid, 0);
    end
    for (int n = 0; n < 10000; n++) begin
      logic [63:0] m;
      int kind = $urandom_range(0, 4);
      m = (kind == 0) ? 64'h0 :
          (kind == 1) ? (64'h1 << $urandom_range(0, 63)) :
          (kind == 2) ? ((64'h1 << $urandom_range(0, 63)) | (64'h1 << $urandom_range(0, 63))) :
          (kind == 3) ? {$urandom(), $urandom()} :
                        (64'($urandom_range(1, 255)) << (8 * $urandom_range(0, 7)));
      step(0, $urandom_range(0, 3) != 0, m, $urandom_range(0, 2) != 0, acc);
    end
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) step(0, 0, 0, 1, acc);
    chk("drain_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
